// File: rtl/bram_equiv_monitor.sv
// Equivalence monitor for NCH true-dual-port memories. Each channel watches one
// armed address, tracks which bytes of it have been written, and compares
// golden vs implementation read data for those bytes once the read latency has
// elapsed. Collisions quarantine a channel until the next arm.
module bram_equiv_monitor #(
   parameter int NCH          = 2,
   parameter int ADDRWIDTH    = 10,
   parameter int DATAWIDTH    = 36,
   parameter int BYTEWIDTH    = 9,
   parameter int RD_LATENCY   = 1,
   parameter int CNT_WIDTH    = 16,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    arm,
   input  logic [NCH*ADDRWIDTH-1:0]                watch_addr,
   input  logic [2*NCH*ADDRWIDTH-1:0]              a,
   input  logic [2*NCH-1:0]                        re,
   input  logic [2*NCH-1:0]                        we,
   input  logic [2*NCH*(DATAWIDTH/BYTEWIDTH)-1:0]  be,
   input  logic [2*NCH*DATAWIDTH-1:0]              rd_gold,
   input  logic [2*NCH*DATAWIDTH-1:0]              rd_gate,
   output logic                                    busy,
   output logic [NCH*(DATAWIDTH/BYTEWIDTH)-1:0]    written,
   output logic [2*NCH-1:0]                        mismatch,
   output logic [NCH-1:0]                          collision,
   output logic                                    fail,
   output logic [CNT_WIDTH-1:0]                    mismatch_count,
   output logic [$clog2(2*NCH)-1:0]                first_fail_port
);

   localparam int NB = DATAWIDTH / BYTEWIDTH;
   localparam int NP = 2 * NCH;
   localparam int PW = $clog2(NP);
   localparam int SW = CNT_WIDTH + PW + 1;   // wide enough for count + all ports

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STOPPED} state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [NCH*ADDRWIDTH-1:0]   r_watch;
   logic [NCH*NB-1:0]          r_written;
   logic [NP-1:0]              r_mismatch;
   logic [NCH-1:0]             r_collision;
   logic [CNT_WIDTH-1:0]       r_count;
   logic [PW-1:0]              r_ffp;

   logic                       w_active;
   logic [NP-1:0]              w_hit;
   logic [NP-1:0]              w_fail;
   logic [NCH-1:0]             w_coll;
   logic [NCH*NB-1:0]          w_wr_set;
   logic [SW-1:0]              w_nfail;
   logic [SW-1:0]              w_sum;
   logic [CNT_WIDTH-1:0]       w_count_next;
   logic [PW-1:0]              w_ffp_idx;

   // An arm pulse takes priority: nothing is tracked or compared in that cycle.
   assign w_active = (r_state == S_ARMED) && !arm;

   // Per-port watch hit, read-token pipeline and byte-masked compare.
   for (genvar gi = 0; gi < NP; gi++) begin : g_port
      localparam int CH = gi / 2;
      logic [RD_LATENCY-1:0] r_tok_valid;
      logic [RD_LATENCY-1:0] r_tok_ok;
      logic [NB-1:0]         r_tok_mask [RD_LATENCY];
      logic [NB-1:0]         w_byte_diff;

      assign w_hit[gi] = (a[gi*ADDRWIDTH +: ADDRWIDTH] == r_watch[CH*ADDRWIDTH +: ADDRWIDTH]);

      for (genvar gj = 0; gj < NB; gj++) begin : g_byte
         assign w_byte_diff[gj] = (rd_gold[gi*DATAWIDTH + gj*BYTEWIDTH +: BYTEWIDTH] !=
                                   rd_gate[gi*DATAWIDTH + gj*BYTEWIDTH +: BYTEWIDTH]);
      end

      assign w_fail[gi] = w_active && r_tok_valid[RD_LATENCY-1] && r_tok_ok[RD_LATENCY-1] &&
                          (|(w_byte_diff & r_tok_mask[RD_LATENCY-1]));

      // Shift read tokens so each one surfaces exactly when its data is valid.
      always_ff @(posedge clk) begin
         if (rst || arm) begin
            r_tok_valid <= '0;
            r_tok_ok    <= '0;
            for (int k = 0; k < RD_LATENCY; k++) r_tok_mask[k] <= '0;
         end else begin
            for (int k = RD_LATENCY-1; k > 0; k--) begin
               r_tok_valid[k] <= r_tok_valid[k-1];
               r_tok_ok[k]    <= r_tok_ok[k-1];
               r_tok_mask[k]  <= r_tok_mask[k-1];
            end
            r_tok_valid[0] <= w_active && re[gi] && w_hit[gi];
            // Quarantine applies already to the colliding cycle's own reads.
            r_tok_ok[0]    <= !(r_collision[CH] || w_coll[CH]);
            // Registered mask: a same-cycle write does not count for this read.
            r_tok_mask[0]  <= r_written[CH*NB +: NB];
         end
      end
   end

   // Per-channel collision detect and write-mask accumulation.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      localparam int PA = 2*gi;
      localparam int PB = 2*gi + 1;
      logic w_same;
      assign w_same = (a[PA*ADDRWIDTH +: ADDRWIDTH] == a[PB*ADDRWIDTH +: ADDRWIDTH]);
      assign w_coll[gi] = w_active && w_same &&
                          ((we[PA] && (we[PB] || re[PB])) || (we[PB] && (we[PA] || re[PA])));
      assign w_wr_set[gi*NB +: NB] = ({NB{we[PA] && w_hit[PA]}} & be[PA*NB +: NB]) |
                                     ({NB{we[PB] && w_hit[PB]}} & be[PB*NB +: NB]);
   end

   // Count failing ports this cycle and find the lowest-index one.
   always_comb begin
      w_nfail   = '0;
      w_ffp_idx = '0;
      for (int i = NP-1; i >= 0; i--) begin
         w_nfail = w_nfail + SW'(w_fail[i]);
         if (w_fail[i]) w_ffp_idx = PW'(i);
      end
      w_sum        = SW'(r_count) + w_nfail;
      w_count_next = (|w_sum[SW-1:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
   end

   // Next-state logic: arm always (re)enters ARMED; a failure may stop monitoring.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:    if (arm) w_state_next = S_ARMED;
         S_ARMED: begin
            if (arm) w_state_next = S_ARMED;
            else if ((STOP_ON_FAIL != 0) && (|w_fail)) w_state_next = S_STOPPED;
         end
         S_STOPPED: if (arm) w_state_next = S_ARMED;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Watch latch, write tracking and sticky result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_watch     <= '0;
         r_written   <= '0;
         r_mismatch  <= '0;
         r_collision <= '0;
         r_count     <= '0;
         r_ffp       <= '0;
      end else if (arm) begin
         r_watch     <= watch_addr;
         r_written   <= '0;
         r_mismatch  <= '0;
         r_collision <= '0;
         r_count     <= '0;
         r_ffp       <= '0;
      end else if (w_active) begin
         r_written   <= r_written | w_wr_set;
         r_collision <= r_collision | w_coll;
         r_mismatch  <= r_mismatch | w_fail;
         r_count     <= w_count_next;
         if ((|w_fail) && !(|r_mismatch)) r_ffp <= w_ffp_idx;
      end
   end

   assign busy            = (r_state == S_ARMED);
   assign written         = r_written;
   assign mismatch        = r_mismatch;
   assign collision       = r_collision;
   assign fail            = |r_mismatch;
   assign mismatch_count  = r_count;
   assign first_fail_port = r_ffp;

endmodule

// File: tb/tb_bram_equiv_monitor.sv
// Bench for bram_equiv_monitor: two instances (keep-going and stop-on-fail)
// share one stimulus stream; a queue-based reference model predicts outputs.
module tb_bram_equiv_monitor;
   localparam int NCH = 2, AW = 6, DW = 36, BW = 9, NB = 4, L = 3, CW = 3, NP = 4;
   localparam int CMAX = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, arm;
   logic [NCH*AW-1:0]   watch_addr;
   logic [NP*AW-1:0]    a;
   logic [NP-1:0]       re, we;
   logic [NP*NB-1:0]    be;
   logic [NP*DW-1:0]    rd_gold, rd_gate;

   logic                d_busy    [2];
   logic [NCH*NB-1:0]   d_written [2];
   logic [NP-1:0]       d_mis     [2];
   logic [NCH-1:0]      d_coll    [2];
   logic                d_fail    [2];
   logic [CW-1:0]       d_cnt     [2];
   logic [1:0]          d_ffp     [2];

   bram_equiv_monitor #(.NCH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW), .BYTEWIDTH(BW),
      .RD_LATENCY(L), .CNT_WIDTH(CW), .STOP_ON_FAIL(0)) u_run (
      .clk(clk), .rst(rst), .arm(arm), .watch_addr(watch_addr), .a(a), .re(re), .we(we),
      .be(be), .rd_gold(rd_gold), .rd_gate(rd_gate), .busy(d_busy[0]), .written(d_written[0]),
      .mismatch(d_mis[0]), .collision(d_coll[0]), .fail(d_fail[0]),
      .mismatch_count(d_cnt[0]), .first_fail_port(d_ffp[0]));

   bram_equiv_monitor #(.NCH(NCH), .ADDRWIDTH(AW), .DATAWIDTH(DW), .BYTEWIDTH(BW),
      .RD_LATENCY(L), .CNT_WIDTH(CW), .STOP_ON_FAIL(1)) u_stop (
      .clk(clk), .rst(rst), .arm(arm), .watch_addr(watch_addr), .a(a), .re(re), .we(we),
      .be(be), .rd_gold(rd_gold), .rd_gate(rd_gate), .busy(d_busy[1]), .written(d_written[1]),
      .mismatch(d_mis[1]), .collision(d_coll[1]), .fail(d_fail[1]),
      .mismatch_count(d_cnt[1]), .first_fail_port(d_ffp[1]));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: mode 0 idle, 1 armed, 2 stopped. Instance 1 stops on fail.
   typedef struct {
      int            inst;
      int            due;
      int            port;
      logic [NB-1:0] mask;
      bit            ok;
   } tok_t;
   tok_t q[$];

   int            m_mode    [2];
   logic [AW-1:0] m_watch   [2][NCH];
   logic [NB-1:0] m_written [2][NCH];
   bit            m_coll    [2][NCH];
   bit            m_mis     [2][NP];
   int            m_cnt     [2];
   int            m_ffp     [2];

   task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] port_addr(input int p);
      return a[p*AW +: AW];
   endfunction

   function automatic bit byte_bad(input int p, input int b);
      return rd_gold[p*DW + b*BW +: BW] != rd_gate[p*DW + b*BW +: BW];
   endfunction

   task automatic model_clear(input int k);
      for (int c = 0; c < NCH; c++) begin
         m_written[k][c] = '0;
         m_coll[k][c]    = 1'b0;
      end
      for (int p = 0; p < NP; p++) m_mis[k][p] = 1'b0;
      m_cnt[k] = 0;
      m_ffp[k] = 0;
   endtask

   task automatic model_step();
      tok_t keep[$];
      cyc++;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_mode[k] = 0;
            for (int c = 0; c < NCH; c++) m_watch[k][c] = '0;
         end
         q.delete();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (arm) begin
               tok_t other[$];
               model_clear(k);
               m_mode[k] = 1;
               for (int c = 0; c < NCH; c++) m_watch[k][c] = watch_addr[c*AW +: AW];
               foreach (q[i]) if (q[i].inst != k) other.push_back(q[i]);
               q = other;
            end else if (m_mode[k] == 1) begin
               bit            coll_now [NCH];
               logic [NB-1:0] wr_or    [NCH];
               bit            failp    [NP];
               int            nfail;
               bit            any_prev;
               nfail = 0;
               for (int p = 0; p < NP; p++) failp[p] = 1'b0;
               for (int c = 0; c < NCH; c++) begin
                  int pa, pb;
                  pa = 2*c; pb = 2*c + 1;
                  coll_now[c] = (port_addr(pa) == port_addr(pb)) &&
                     ((we[pa] && (we[pb] || re[pb])) || (we[pb] && (we[pa] || re[pa])));
                  wr_or[c] = '0;
               end
               foreach (q[i]) begin
                  if (q[i].inst == k && q[i].due == cyc && q[i].ok) begin
                     for (int b = 0; b < NB; b++)
                        if (q[i].mask[b] && byte_bad(q[i].port, b)) failp[q[i].port] = 1'b1;
                  end
               end
               for (int p = 0; p < NP; p++) begin
                  int c;
                  c = p / 2;
                  if (port_addr(p) == m_watch[k][c]) begin
                     if (re[p]) begin
                        tok_t t;
                        t.inst = k; t.due = cyc + L; t.port = p;
                        t.mask = m_written[k][c];
                        t.ok   = !(m_coll[k][c] || coll_now[c]);
                        q.push_back(t);
                     end
                     if (we[p]) wr_or[c] = wr_or[c] | be[p*NB +: NB];
                  end
               end
               any_prev = 1'b0;
               for (int p = 0; p < NP; p++) any_prev = any_prev | m_mis[k][p];
               for (int p = NP-1; p >= 0; p--) begin
                  if (failp[p]) begin
                     nfail++;
                     if (!any_prev) m_ffp[k] = p;
                  end
               end
               for (int p = 0; p < NP; p++) m_mis[k][p] = m_mis[k][p] | failp[p];
               for (int c = 0; c < NCH; c++) begin
                  m_written[k][c] = m_written[k][c] | wr_or[c];
                  m_coll[k][c]    = m_coll[k][c] | coll_now[c];
               end
               m_cnt[k] = (m_cnt[k] + nfail > CMAX) ? CMAX : m_cnt[k] + nfail;
               if (k == 1 && nfail > 0) m_mode[k] = 2;
            end
         end
         foreach (q[i]) if (q[i].due > cyc) keep.push_back(q[i]);
         q = keep;
      end
   endtask

   always @(posedge clk) model_step();

   // Compare every DUT output against the model on every cycle.
   always @(negedge clk) begin : cmp
      logic [NCH*NB-1:0] ew;
      logic [NP-1:0]     em;
      logic [NCH-1:0]    ec;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NCH; c++) begin
            ew[c*NB +: NB] = m_written[k][c];
            ec[c] = m_coll[k][c];
         end
         for (int p = 0; p < NP; p++) em[p] = m_mis[k][p];
         chk("busy",      k, 32'(d_busy[k]),    32'(m_mode[k] == 1));
         chk("written",   k, 32'(d_written[k]), 32'(ew));
         chk("mismatch",  k, 32'(d_mis[k]),     32'(em));
         chk("collision", k, 32'(d_coll[k]),    32'(ec));
         chk("fail",      k, 32'(d_fail[k]),    32'(|em));
         chk("count",     k, 32'(d_cnt[k]),     32'(m_cnt[k]));
         chk("ffp",       k, 32'(d_ffp[k]),     32'(m_ffp[k]));
      end
   end

   task automatic cyc_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ports();
      arm = 1'b0; re = '0; we = '0; be = '0; a = '0;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] ad, input bit r, input bit w, input logic [NB-1:0] bm);
      a[p*AW +: AW] = ad; re[p] = r; we[p] = w; be[p*NB +: NB] = bm;
   endtask

   task automatic corrupt(input int p, input int b);
      rd_gate[p*DW + b*BW] = ~rd_gold[p*DW + b*BW];
   endtask

   task automatic do_arm();
      arm = 1'b1; cyc_step(); arm = 1'b0;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 4))
         0: return AW'(5);
         1: return AW'(6);
         2: return AW'(16);
         3: return AW'(32);
         default: return AW'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      rst = 1'b1; watch_addr = '0;
      clear_ports();
      rd_gold = {4{36'h123456789}};
      rd_gate = rd_gold;
      repeat (3) cyc_step();
      chk("lit_reset_busy", 0, 32'(d_busy[0]), 0);
      chk("lit_reset_cnt",  0, 32'(d_cnt[0]), 0);
      rst = 1'b0;

      // Basic write then clean read.
      watch_addr = {6'h20, 6'h05};
      do_arm();
      chk("lit_armed_busy", 0, 32'(d_busy[0]), 1);
      set_port(0, 6'h05, 0, 1, 4'b0011); cyc_step(); clear_ports();
      set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); clear_ports();
      repeat (4) cyc_step();
      chk("lit_written", 0, 32'(d_written[0]), 32'h03);
      chk("lit_nofail",  0, 32'(d_fail[0]), 0);

      // Difference only in unwritten byte 3: no mismatch.
      corrupt(1, 3);
      set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); clear_ports();
      repeat (4) cyc_step();
      rd_gate = rd_gold;
      chk("lit_unwritten_byte", 0, 32'(d_fail[0]), 0);

      // Difference in byte 0: flag appears L cycles + 1 register after request.
      corrupt(1, 0);
      set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); clear_ports();
      repeat (L-1) cyc_step();
      chk("lit_latency_early", 0, 32'(d_mis[0]), 0);
      cyc_step();
      chk("lit_latency_mis", 0, 32'(d_mis[0]), 32'b0010);
      chk("lit_latency_cnt", 0, 32'(d_cnt[0]), 1);
      chk("lit_latency_ffp", 0, 32'(d_ffp[0]), 1);
      chk("lit_stop_busy",   1, 32'(d_busy[1]), 0);
      rd_gate = rd_gold;

      // Five back-to-back mismatching reads.
      do_arm();
      set_port(0, 6'h05, 0, 1, 4'b1111); cyc_step(); clear_ports();
      corrupt(1, 0);
      repeat (5) begin set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); end
      clear_ports();
      repeat (5) cyc_step();
      rd_gate = rd_gold;
      chk("lit_b2b_cnt",      0, 32'(d_cnt[0]), 5);
      chk("lit_b2b_cnt_stop", 1, 32'(d_cnt[1]), 1);
      chk("lit_model_cnt",    0, 32'(m_cnt[0]), 5);

      // Collision at a non-watch address quarantines the channel.
      do_arm();
      set_port(0, 6'h10, 0, 1, 4'b1111); set_port(1, 6'h10, 1, 0, 4'b0000); cyc_step(); clear_ports();
      chk("lit_coll_set", 0, 32'(d_coll[0]), 32'b01);
      set_port(0, 6'h05, 0, 1, 4'b1111); cyc_step(); clear_ports();
      corrupt(1, 0);
      set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); clear_ports();
      repeat (4) cyc_step();
      rd_gate = rd_gold;
      chk("lit_coll_quar", 0, 32'(d_mis[0]), 0);
      do_arm();
      chk("lit_coll_clear", 0, 32'(d_coll[0]), 0);

      // Simultaneous first failures on ports 1 and 3.
      set_port(0, 6'h05, 0, 1, 4'b1111); set_port(2, 6'h20, 0, 1, 4'b1111); cyc_step(); clear_ports();
      corrupt(1, 0); corrupt(3, 0);
      set_port(1, 6'h05, 1, 0, 4'b0000); set_port(3, 6'h20, 1, 0, 4'b0000); cyc_step(); clear_ports();
      repeat (4) cyc_step();
      chk("lit_sim_ffp", 0, 32'(d_ffp[0]), 1);
      chk("lit_sim_cnt", 0, 32'(d_cnt[0]), 2);
      chk("lit_sim_mis", 0, 32'(d_mis[0]), 32'b1010);
      chk("lit_model_ffp", 0, 32'(m_ffp[0]), 1);

      // Reset with tokens in flight.
      set_port(1, 6'h05, 1, 0, 4'b0000); set_port(3, 6'h20, 1, 0, 4'b0000); cyc_step(); clear_ports();
      rst = 1'b1; cyc_step(); rst = 1'b0;
      chk("lit_rst_cnt", 0, 32'(d_cnt[0]), 0);
      chk("lit_rst_mis", 0, 32'(d_mis[0]), 0);
      repeat (5) cyc_step();
      chk("lit_rst_hold", 0, 32'(d_mis[0]), 0);
      rd_gate = rd_gold;

      // Saturation of the 3-bit counter.
      do_arm();
      set_port(0, 6'h05, 0, 1, 4'b1111); cyc_step(); clear_ports();
      corrupt(1, 0);
      repeat (9) begin set_port(1, 6'h05, 1, 0, 4'b0000); cyc_step(); end
      clear_ports();
      repeat (5) cyc_step();
      rd_gate = rd_gold;
      chk("lit_sat_cnt", 0, 32'(d_cnt[0]), 7);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         arm = !rst && ($urandom_range(0, 29) == 0);
         for (int c = 0; c < NCH; c++) watch_addr[c*AW +: AW] = pick_addr();
         for (int p = 0; p < NP; p++) begin
            a[p*AW +: AW] = pick_addr();
            re[p] = ($urandom_range(0, 1) == 1);
            we[p] = ($urandom_range(0, 5) == 0);
            be[p*NB +: NB] = NB'($urandom);
            for (int b = 0; b < NB; b++) rd_gold[p*DW + b*BW +: BW] = BW'($urandom);
         end
         rd_gate = rd_gold;
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 3) == 0) corrupt(p, $urandom_range(0, NB-1));
         cyc_step();
      end
      rst = 1'b0;
      clear_ports();
      cyc_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bram_equiv_monitor.md
Name: bram_equiv_monitor

Overview:
- Synthesizable, parametrised successor to the formal split-TDP BRAM miter.
- Watches NCH independent true-dual-port memories, each with ports A and B. For each memory it compares read data from a golden model (`rd_gold`) against the mapped implementation (`rd_gate`) at one armed watch address per memory.
- Only bytes known to have been written are compared.
- Adds what the formal miter lacks: configurable read latency, collision detection with channel quarantine, sticky per-port mismatch flags, a saturating mismatch counter, and an arm/stop state machine.
- Used in simulation benches and on-chip BIST around QLF BRAM tests.

Parameters:
- NCH, 2, number of TDP memories (channels); each channel has ports A (index 2c) and B (index 2c+1).
- ADDRWIDTH, 10, address width; identical for all ports.
- DATAWIDTH, 36, read/write data width per port.
- BYTEWIDTH, 9, byte-lane width; DATAWIDTH must be a multiple of it; NB = DATAWIDTH/BYTEWIDTH.
- RD_LATENCY, 1, cycles from read request to valid rd_gold/rd_gate; legal range 1..4.
- CNT_WIDTH, 16, width of the mismatch counter.
- STOP_ON_FAIL, 1, 1 = stop comparing after the first mismatch; 0 = keep comparing.

Ports:
- clk  in  1  single clock for all ports and channels.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; latches watch_addr and starts monitoring.
- watch_addr  in  NCH*ADDRWIDTH  per-channel watch address; sampled only on arm.
- a  in  2*NCH*ADDRWIDTH  per-port address.
- re  in  2*NCH  per-port read enable.
- we  in  2*NCH  per-port write enable.
- be  in  2*NCH*NB  per-port byte enables.
- rd_gold  in  2*NCH*DATAWIDTH  golden read data.
- rd_gate  in  2*NCH*DATAWIDTH  implementation read data.
- busy  out  1  high in ARMED.
- written  out  NCH*NB  per-channel mask of bytes written at the watch address.
- mismatch  out  2*NCH  sticky per-port mismatch flag.
- collision  out  NCH  sticky per-channel collision flag.
- fail  out  1  OR of mismatch.
- mismatch_count  out  CNT_WIDTH  saturating count of mismatching compares.
- first_fail_port  out  $clog2(2*NCH)  lowest-index port of the first failing compare.

Behaviour:
- Reset: all outputs 0; state IDLE; watch registers 0; compare pipeline flushed. Reset mid-operation discards in-flight compares (none complete after rst).
- State machine:
  - IDLE: arm -> ARMED. Latch watch_addr, clear written, mismatch, collision, mismatch_count and first_fail_port.
  - ARMED: arm -> re-arm, same clears as from IDLE, pipeline flushed. If a mismatch is detected and STOP_ON_FAIL=1 -> STOPPED.
  - STOPPED: outputs hold; arm -> ARMED.
- Write tracking (ARMED only):
  - Port p with we[p] and a[p]==watch[c] sets written[c] |= be[p] in the next cycle.
  - A and B writes in the same cycle OR together.
- Read capture (ARMED only):
  - Port p with re[p] and a[p]==watch[c] pushes a token {valid, mask=written[c], chan_ok=!collision[c]} into a per-port RD_LATENCY-deep shift pipeline.
  - mask is the registered pre-update value: a same-cycle write to the watch address is not counted as written for that read.
- Compare:
  - When the token exits the pipeline (exactly RD_LATENCY cycles after the request) with valid && chan_ok, compare each byte i where mask[i]=1.
  - Any byte differing -> the compare fails.
- On a failing compare:
  - mismatch[p] set next cycle.
  - mismatch_count increments by the number of failing ports that cycle; saturates at all-ones.
  - first_fail_port loaded only on the first failure since arm; on simultaneous first failures, the lowest index wins.
- Collision:
  - Condition: in channel c, one port has we while the other port has we or re, both at the same address (any address, not just watch).
  - Effect: collision[c] set next cycle; tokens for channel c issued from that cycle on carry chan_ok=0 until re-arm.
  - The colliding cycle's own reads are also quarantined.
- No compares in IDLE or STOPPED; tokens already in flight when the machine enters STOPPED are dropped.
- Widths: all address compares are full-width equality. No wrap-around; the watch address is fixed until the next arm.

Test Plan:
- NCH=1, RD_LATENCY=1:
  - Arm watch=0x005. Write port A a=0x005, be=4'b0011. Read port B a=0x005 with rd_gold==rd_gate next cycle -> written=4'b0011, fail=0, mismatch_count=0.
  - Same setup, but rd_gate differs only in byte 3 (unwritten) -> no mismatch. Differs in byte 0 -> mismatch[1]=1, count=1, first_fail_port=1.
- RD_LATENCY=3, STOP_ON_FAIL=0: 5 back-to-back mismatching reads -> flag set exactly 3 cycles after the first request +1 register; count=5.
- Port A we and port B re at the same address 0x010 in one cycle -> collision[0]=1. A later mismatching watch read produces no flag. Re-arm clears collision.
- NCH=2: simultaneous first failures on ports 3 and 1 -> first_fail_port=1, count=2. Then assert rst with tokens in flight -> all outputs 0 the next cycle and stay 0.
- CNT_WIDTH=2, STOP_ON_FAIL=0: 6 mismatches -> mismatch_count holds 3.
